// File: rtl/enemy_inflate_pkg.sv
// enemy_inflate_pkg: shared FSM states, keycodes, screen limits, pump geometry and overlap helper
package enemy_inflate_pkg;
  typedef enum logic [1:0] {ROAM, INFLATE, POP, DEAD} state_e;
  localparam logic [7:0] KEY_W = 8'd26;
  localparam logic [7:0] KEY_S = 8'd22;
  localparam logic [7:0] KEY_D = 8'd7;
  localparam logic [7:0] KEY_A = 8'd4;
  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam int SCREEN_H = 480;
  localparam int SCREEN_W = 512;
  localparam int PUMP_HALF = 4;
  localparam int PUMP_NEAR = 8;
  localparam int PUMP_FAR = 24;
  localparam int ENEMY_HALF = 8;
  function automatic logic overlaps(input logic [9:0] b, input logic [9:0] e, input int lo, input int hi);
    logic [10:0] bw;
    logic [10:0] ew;
    bw = {1'b0, b};
    ew = {1'b0, e};
    return ((lo < ENEMY_HALF) ? bw <= ew + 11'(ENEMY_HALF - 1 - lo) : bw + 11'(lo - ENEMY_HALF + 1) <= ew)
        && ew <= bw + 11'(hi + ENEMY_HALF);
  endfunction
endpackage

// File: rtl/enemy_inflate_pump_hit_detect.sv
// pump_hit_detect: ball_x/ball_y player centre, enemy_x/enemy_y enemy centre, key direction -> hit when the pump rectangle overlaps the enemy box
module pump_hit_detect
  import enemy_inflate_pkg::*;
(
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] enemy_x,
  input  logic [9:0] enemy_y,
  input  logic [7:0] key,
  output logic       hit
);
  logic [10:0] bx;
  logic [10:0] by;
  logic hit_w;
  logic hit_s;
  logic hit_d;
  logic hit_a;
  always_comb begin
    bx = {1'b0, ball_x};
    by = {1'b0, ball_y};
    hit_w = by >= 11'(PUMP_FAR)
         && overlaps(ball_x, enemy_x, -PUMP_HALF, PUMP_HALF)
         && overlaps(ball_y, enemy_y, -PUMP_FAR, -PUMP_NEAR);
    hit_s = by + 11'(PUMP_FAR) < 11'(SCREEN_H)
         && overlaps(ball_x, enemy_x, -PUMP_HALF, PUMP_HALF)
         && overlaps(ball_y, enemy_y, PUMP_NEAR, PUMP_FAR);
    hit_d = bx + 11'(PUMP_FAR) < 11'(SCREEN_W)
         && overlaps(ball_x, enemy_x, PUMP_NEAR, PUMP_FAR)
         && overlaps(ball_y, enemy_y, -PUMP_HALF, PUMP_HALF);
    hit_a = bx >= 11'(PUMP_FAR)
         && overlaps(ball_x, enemy_x, -PUMP_FAR, -PUMP_NEAR)
         && overlaps(ball_y, enemy_y, -PUMP_HALF, PUMP_HALF);
    hit = key == KEY_W ? hit_w : key == KEY_S ? hit_s : key == KEY_D ? hit_d : key == KEY_A ? hit_a : 1'b0;
  end
endmodule

// File: rtl/enemy_inflate.sv
// enemy_inflate: frame-ticked pump/inflate/pop/dead enemy FSM; in: Clk, Reset, frame_clk, pump_enable, last_key_press, player/enemy centres, enemy_respawn; out: inflate_level, enemy_freeze, enemy_popped, enemy_dead, score_pulse
module enemy_inflate
  import enemy_inflate_pkg::*;
#(
  parameter int DEFLATE_FRAMES = 60,
  parameter int POP_FRAMES = 30,
  parameter int MAX_LEVEL = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       pump_enable,
  input  logic [7:0] last_key_press,
  input  logic [9:0] Ball_X_Loc,
  input  logic [9:0] Ball_Y_Loc,
  input  logic [9:0] Enemy_X_Loc,
  input  logic [9:0] Enemy_Y_Loc,
  input  logic       enemy_respawn,
  output logic [2:0] inflate_level,
  output logic       enemy_freeze,
  output logic       enemy_popped,
  output logic       enemy_dead,
  output logic       score_pulse
);
  state_e state;
  state_e nxt_state;
  logic [2:0] nxt_level;
  logic [15:0] dcnt;
  logic [15:0] nxt_dcnt;
  logic [15:0] pcnt;
  logic [15:0] nxt_pcnt;
  logic frame_r;
  logic frame_p;
  logic pump_p;
  logic tick;
  logic pump;
  logic hit;
  pump_hit_detect u_hit (
    .ball_x (Ball_X_Loc),
    .ball_y (Ball_Y_Loc),
    .enemy_x(Enemy_X_Loc),
    .enemy_y(Enemy_Y_Loc),
    .key    (last_key_press),
    .hit    (hit)
  );
  always_comb begin
    tick = frame_r & ~frame_p;
    pump = tick & pump_enable & ~pump_p & hit;
    nxt_state = state;
    nxt_level = inflate_level;
    nxt_dcnt = dcnt;
    nxt_pcnt = pcnt;
    case (state)
      ROAM: if (pump) begin
        nxt_state = INFLATE;
        nxt_level = 3'd1;
        nxt_dcnt = '0;
      end
      INFLATE: if (pump) begin
        nxt_level = inflate_level + 3'd1;
        nxt_dcnt = '0;
        if (nxt_level == 3'(MAX_LEVEL)) begin
          nxt_state = POP;
          nxt_pcnt = '0;
        end
      end else if (tick) begin
        nxt_dcnt = dcnt == 16'(DEFLATE_FRAMES - 1) ? '0 : dcnt + 16'd1;
        if (dcnt == 16'(DEFLATE_FRAMES - 1)) begin
          nxt_level = inflate_level - 3'd1;
          nxt_state = inflate_level == 3'd1 ? ROAM : INFLATE;
        end
      end
      POP: if (tick) begin
        nxt_pcnt = pcnt == 16'(POP_FRAMES - 1) ? '0 : pcnt + 16'd1;
        if (pcnt == 16'(POP_FRAMES - 1)) begin
          nxt_state = DEAD;
          nxt_level = '0;
        end
      end
      DEAD: if (enemy_respawn) begin
        nxt_state = ROAM;
        nxt_dcnt = '0;
        nxt_pcnt = '0;
      end
      default: nxt_state = ROAM;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ROAM;
      inflate_level <= '0;
      dcnt <= '0;
      pcnt <= '0;
      frame_r <= 1'b0;
      frame_p <= 1'b0;
      pump_p <= 1'b0;
      enemy_freeze <= 1'b0;
      enemy_popped <= 1'b0;
      enemy_dead <= 1'b0;
      score_pulse <= 1'b0;
    end else begin
      frame_r <= frame_clk;
      frame_p <= frame_r;
      pump_p <= tick ? pump_enable : pump_p;
      state <= nxt_state;
      inflate_level <= nxt_level;
      dcnt <= nxt_dcnt;
      pcnt <= nxt_pcnt;
      enemy_freeze <= nxt_level != 3'd0 || nxt_state == POP;
      enemy_popped <= nxt_state == POP;
      enemy_dead <= nxt_state == DEAD;
      score_pulse <= nxt_state == POP && state != POP;
    end
  end
endmodule

// File: doc/enemy_inflate.md
ENEMY_INFLATE -- requirements
Module: enemy_inflate

Interface
Parameters (name, default, meaning):
REQ-001 DEFLATE_FRAMES, 60, frames without a fresh pump hit before inflate level drops by one.
REQ-002 POP_FRAMES, 30, frames the popped sprite is held before the enemy is dead.
REQ-003 MAX_LEVEL, 4, inflate level at which the enemy pops.
Ports (name, direction, width, meaning):
REQ-004 Clk  input  1  system clock; the only clock; all state on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 frame_clk  input  1  vertical-sync frame strobe, sampled in Clk domain.
REQ-007 pump_enable  input  1  high while the pump key (keycode 44) is held.
REQ-008 last_key_press  input  8  last direction key (W=26, S=22, D=7, A=4).
REQ-009 Ball_X_Loc, Ball_Y_Loc  input  10 each  player centre.
REQ-010 Enemy_X_Loc, Enemy_Y_Loc  input  10 each  enemy centre; enemy box is [X-8, X+7] x [Y-8, Y+7].
REQ-011 enemy_respawn  input  1  one-cycle request to revive a dead enemy.
REQ-012 inflate_level  output  3  current level 0..MAX_LEVEL.
REQ-013 enemy_freeze  output  1  high when level > 0 or in POP; enemy motion halts.
REQ-014 enemy_popped  output  1  high during POP (sprite select).
REQ-015 enemy_dead  output  1  high in DEAD.
REQ-016 score_pulse  output  1  one Clk cycle high on entry to POP.

Function
REQ-017 Frame tick = one-Clk-cycle pulse on a 0->1 transition of registered frame_clk; all game-state updates occur only on frame ticks.
REQ-018 Pump rectangle by direction: W x[Bx-4,Bx+4] y[By-24,By-8] valid only if By>23; S x[Bx-4,Bx+4] y[By+8,By+24] valid only if By+24<480; D x[Bx+8,Bx+24] y[By-4,By+4] valid only if Bx+24<512; A x[Bx-24,Bx-8] y[By-4,By+4] valid only if Bx>23; any other key = no rectangle.
REQ-019 hit = valid rectangle overlapping enemy box, inclusive bounds; comparisons computed in 11 bits, rearranged to avoid subtraction underflow.
REQ-020 press = pump_enable sampled high at this tick and low at the previous tick (holding the key counts once).
REQ-021 States: ROAM, INFLATE, POP, DEAD.
REQ-022 ROAM: level 0; on tick with press && hit -> INFLATE, level 1, deflate counter cleared.
REQ-023 INFLATE: tick with press && hit -> level+1, counter cleared; if new level = MAX_LEVEL -> POP, pop counter cleared, score_pulse asserted that cycle.
REQ-024 INFLATE: tick without press&&hit -> counter+1; at DEFLATE_FRAMES counter clears and level-1; level reaching 0 -> ROAM.
REQ-025 A press && hit on the same tick as deflate expiry: the increment wins, no decrement.
REQ-026 POP: level held at MAX_LEVEL; pump ignored; after POP_FRAMES ticks -> DEAD, level 0.
REQ-027 DEAD: pump ignored; enemy_respawn (any cycle, no tick needed) -> ROAM next cycle, counters cleared; enemy_respawn ignored in other states.
REQ-028 Outputs are registered, decoded from state/level; one-cycle latency from the deciding tick.

Reset
REQ-029 Reset forces state ROAM, level 0, all counters 0, sampled frame_clk and pump_enable registers 0; outputs inflate_level=0, enemy_freeze=0, enemy_popped=0, enemy_dead=0, score_pulse=0 the cycle after Reset.
REQ-030 Reset asserted mid-INFLATE or mid-POP aborts with no score_pulse; Reset takes priority over every other input.

Structure
REQ-031 Shared package holds: state enum, keycode constants (KEY_W, KEY_S, KEY_D, KEY_A, KEY_SPACE), screen limits (480, 512), pump geometry offsets (4, 8, 24), enemy half-size 8.
REQ-032 Sub-module pump_hit_detect (combinational rectangle/overlap from REQ-018/019), reusable by later enemy instances.

Verification
REQ-033 Player (100,100) key D, enemy (120,100), three pump presses on separate ticks -> level 1,2,3, freeze high.
REQ-034 Same setup, fourth press -> POP, score_pulse exactly one cycle, popped high 30 ticks, then dead=1, level 0.
REQ-035 Level 2, no presses for 60 ticks -> level 1; further 60 ticks -> ROAM, freeze low.
REQ-036 Pump held high for 10 ticks while hitting -> level rises by exactly 1.
REQ-037 Player (500,100) key D (500+24>=512), enemy (520,100) -> no hit, level stays 0; player (10,100) key A -> no hit.
REQ-038 Reset pulsed at level 3 -> all outputs 0 next cycle; enemy_respawn in DEAD -> ROAM next cycle, dead low.
